// File: rtl/matrix_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : matrix_uart_tx
// Purpose  : Reads an m x n matrix of 32-bit unsigned values row-major from
//            storage, converts each element to decimal ASCII and sends the
//            text on a UART line (8N1). Elements in a row are separated by a
//            single space, each row ends in CR LF, and there is no trailing
//            space. Leading zeros are suppressed; a zero value prints "0".
// Options  : `define MATRIX_UART_TX_HEADER_EN to prefix the output with the
//            header "m*n" CR LF built from the clamped dimensions.
// Ports    : clk          system clock
//            rst_n        asynchronous active-low reset
//            i_start      start pulse, ignored while busy or in the done cycle
//            i_base_addr  storage address of element (0,0)
//            i_m, i_n     row / column counts, clamped to MAX_DIM
//            o_rd_addr    storage read address
//            i_rd_data    storage read data, valid one cycle after o_rd_addr
//            o_busy       transfer in progress
//            o_done       one-cycle pulse after the last stop bit
//            o_uart_tx    serial line, idle high
// Revision : 1.0 - initial release
// ============================================================================
module matrix_uart_tx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int MAX_DIM      = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [8:0]  i_base_addr,
    input  logic [31:0] i_m,
    input  logic [31:0] i_n,
    output logic [8:0]  o_rd_addr,
    input  logic [31:0] i_rd_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_uart_tx
);

    localparam int DIM_W = $clog2(MAX_DIM + 1);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [DIM_W-1:0] DIM_ONE  = DIM_W'(1);
    localparam logic [DIM_W-1:0] DIM_MAX  = DIM_W'(MAX_DIM);
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_SETUP      = 4'd1,
        S_RD_REQ     = 4'd2,
        S_RD_WAIT    = 4'd3,
        S_CONV       = 4'd4,
        S_SEND_DIGIT = 4'd5,
        S_SEP        = 4'd6,
        S_DRAIN      = 4'd7,
        S_DONE       = 4'd8
    } state_t;

    // Which number the converter is currently printing.
    typedef enum logic [1:0] {
        PH_HDR_M = 2'd0,
        PH_HDR_N = 2'd1,
        PH_ELEM  = 2'd2
    } phase_t;

    state_t            state_q, state_d;
    phase_t            phase_q, phase_d;
    logic [8:0]        addr_q, addr_d;
    logic [DIM_W-1:0]  m_q, m_d, n_q, n_d;
    logic [DIM_W-1:0]  row_q, row_d, col_q, col_d;
    logic [31:0]       val_q, val_d;
    logic [3:0]        pidx_q, pidx_d;
    logic [3:0]        digit_q, digit_d;
    logic              started_q, started_d;
    logic              last_q, last_d;
    logic [7:0]        byte_q, byte_d;
    logic              sep2_q, sep2_d;

    logic              push;
    logic [7:0]        push_byte;
    logic [DIM_W-1:0]  m_clamp, n_clamp;
    logic [31:0]       pow;

    // Serialiser: one holding byte in front of a 10-bit frame shifter, so
    // the next byte is queued long before the current stop bit ends.
    logic              hold_valid_q;
    logic [7:0]        hold_byte_q;
    logic              tx_active_q;
    logic [9:0]        tx_shift_q;
    logic [3:0]        tx_bit_q;
    logic [CNT_W-1:0]  tx_cnt_q;
    logic              frame_end;
    logic              tx_load;

    // Power of ten selected by the converter index (index 0 -> 10^9).
    function automatic logic [31:0] pow10(input logic [3:0] idx);
        case (idx)
            4'd0:    return 32'd1000000000;
            4'd1:    return 32'd100000000;
            4'd2:    return 32'd10000000;
            4'd3:    return 32'd1000000;
            4'd4:    return 32'd100000;
            4'd5:    return 32'd10000;
            4'd6:    return 32'd1000;
            4'd7:    return 32'd100;
            4'd8:    return 32'd10;
            default: return 32'd1;
        endcase
    endfunction

    always_comb begin
        m_clamp = (i_m > 32'(MAX_DIM)) ? DIM_MAX : i_m[DIM_W-1:0];
        n_clamp = (i_n > 32'(MAX_DIM)) ? DIM_MAX : i_n[DIM_W-1:0];
        pow     = pow10(pidx_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            phase_q   <= PH_ELEM;
            addr_q    <= 9'd0;
            m_q       <= '0;
            n_q       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            val_q     <= 32'd0;
            pidx_q    <= 4'd0;
            digit_q   <= 4'd0;
            started_q <= 1'b0;
            last_q    <= 1'b0;
            byte_q    <= 8'h00;
            sep2_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            addr_q    <= addr_d;
            m_q       <= m_d;
            n_q       <= n_d;
            row_q     <= row_d;
            col_q     <= col_d;
            val_q     <= val_d;
            pidx_q    <= pidx_d;
            digit_q   <= digit_d;
            started_q <= started_d;
            last_q    <= last_d;
            byte_q    <= byte_d;
            sep2_q    <= sep2_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        addr_d    = addr_q;
        m_d       = m_q;
        n_d       = n_q;
        row_d     = row_q;
        col_d     = col_q;
        val_d     = val_q;
        pidx_d    = pidx_q;
        digit_d   = digit_q;
        started_d = started_q;
        last_d    = last_q;
        byte_d    = byte_q;
        sep2_d    = sep2_q;
        push      = 1'b0;
        push_byte = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    addr_d  = i_base_addr;
                    m_d     = m_clamp;
                    n_d     = n_clamp;
                    row_d   = '0;
                    col_d   = '0;
                    sep2_d  = 1'b0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
`ifdef MATRIX_UART_TX_HEADER_EN
                val_d     = 32'(m_q);
                phase_d   = PH_HDR_M;
                pidx_d    = 4'd0;
                digit_d   = 4'd0;
                started_d = 1'b0;
                state_d   = S_CONV;
`else
                phase_d = PH_ELEM;
                state_d = (m_q == '0 || n_q == '0) ? S_DONE : S_RD_REQ;
`endif
            end
            S_RD_REQ: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                val_d     = i_rd_data;
                pidx_d    = 4'd0;
                digit_d   = 4'd0;
                started_d = 1'b0;
                state_d   = S_CONV;
            end
            S_CONV: begin
                if (val_q >= pow) begin
                    val_d   = val_q - pow;
                    digit_d = digit_q + 4'd1;
                end else begin
                    // Power finished: the units position always prints so
                    // that a zero value still yields "0".
                    digit_d = 4'd0;
                    if (pidx_q != 4'd9)
                        pidx_d = pidx_q + 4'd1;
                    if (started_q || digit_q != 4'd0 || pidx_q == 4'd9) begin
                        byte_d    = {4'h3, digit_q};
                        last_d    = (pidx_q == 4'd9);
                        started_d = 1'b1;
                        state_d   = S_SEND_DIGIT;
                    end
                end
            end
            S_SEND_DIGIT: begin
                if (!hold_valid_q) begin
                    push      = 1'b1;
                    push_byte = byte_q;
                    state_d   = last_q ? S_SEP : S_CONV;
                end
            end
            S_SEP: begin
                if (!hold_valid_q) begin
                    push = 1'b1;
                    if (phase_q == PH_HDR_M) begin
                        push_byte = CH_STAR;
                        val_d     = 32'(n_q);
                        phase_d   = PH_HDR_N;
                        pidx_d    = 4'd0;
                        digit_d   = 4'd0;
                        started_d = 1'b0;
                        state_d   = S_CONV;
                    end else if (!sep2_q && phase_q == PH_ELEM && col_q != n_q - DIM_ONE) begin
                        push_byte = CH_SPACE;
                        col_d     = col_q + DIM_ONE;
                        addr_d    = addr_q + 9'd1;
                        state_d   = S_RD_REQ;
                    end else if (!sep2_q) begin
                        push_byte = CH_CR;
                        sep2_d    = 1'b1;
                    end else begin
                        push_byte = CH_LF;
                        sep2_d    = 1'b0;
                        if (phase_q == PH_HDR_N) begin
                            phase_d = PH_ELEM;
                            state_d = (m_q == '0 || n_q == '0) ? S_DRAIN : S_RD_REQ;
                        end else begin
                            col_d = '0;
                            if (row_q == m_q - DIM_ONE) begin
                                state_d = S_DRAIN;
                            end else begin
                                row_d   = row_q + DIM_ONE;
                                addr_d  = addr_q + 9'd1;
                                state_d = S_RD_REQ;
                            end
                        end
                    end
                end
            end
            S_DRAIN: begin
                // Leave on the final stop-bit cycle so o_done lands in the
                // cycle right after it.
                if (!hold_valid_q && (!tx_active_q || frame_end))
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign frame_end = tx_active_q && (tx_cnt_q == CNT_LAST) && (tx_bit_q == 4'd9);
    assign tx_load   = hold_valid_q && (!tx_active_q || frame_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            hold_byte_q  <= 8'h00;
            tx_active_q  <= 1'b0;
            tx_shift_q   <= 10'h3FF;
            tx_bit_q     <= 4'd0;
            tx_cnt_q     <= '0;
        end else begin
            if (tx_load) begin
                hold_valid_q <= 1'b0;
                tx_active_q  <= 1'b1;
                tx_shift_q   <= {1'b1, hold_byte_q, 1'b0};
                tx_bit_q     <= 4'd0;
                tx_cnt_q     <= '0;
            end else if (tx_active_q) begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_q <= '0;
                    if (tx_bit_q == 4'd9) begin
                        tx_active_q <= 1'b0;
                    end else begin
                        tx_bit_q   <= tx_bit_q + 4'd1;
                        tx_shift_q <= {1'b1, tx_shift_q[9:1]};
                    end
                end else begin
                    tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                end
            end
            // Pushes only happen while the holding byte is empty, so they
            // never collide with a load.
            if (push) begin
                hold_valid_q <= 1'b1;
                hold_byte_q  <= push_byte;
            end
        end
    end

    assign o_uart_tx = tx_active_q ? tx_shift_q[0] : 1'b1;
    assign o_rd_addr = addr_q;
    assign o_busy    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign o_done    = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_matrix_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_uart_tx
// Purpose  : Directed self-checking bench for matrix_uart_tx. A storage model
//            answers reads one cycle later, a UART receiver decodes the line
//            and a run-length probe measures bit widths at the pin.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_uart_tx;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [8:0]  i_base_addr = 9'd0;
    logic [31:0] i_m = 32'd0;
    logic [31:0] i_n = 32'd0;
    logic [8:0]  o_rd_addr;
    logic [31:0] i_rd_data;
    logic        o_busy;
    logic        o_done;
    logic        o_uart_tx;

    matrix_uart_tx #(.CLKS_PER_BIT(CPB), .MAX_DIM(5)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_m         (i_m),
        .i_n         (i_n),
        .o_rd_addr   (o_rd_addr),
        .i_rd_data   (i_rd_data),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_uart_tx   (o_uart_tx)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] bq_t[$];

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [512];
    always @(posedge clk) i_rd_data <= mem[o_rd_addr];

    // ---------------- monitors ----------------
    logic [7:0] rxq[$];
    int         rx_cnt = 0;
    logic       rx_busy = 1'b0;
    logic [7:0] rx_sh = 8'h00;
    int         rx_bad = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_busy <= 1'b0;
        end else if (!rx_busy) begin
            if (o_uart_tx == 1'b0) begin
                rx_busy <= 1'b1;
                rx_cnt  <= 1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt % CPB == CPB / 2) begin
                if (rx_cnt / CPB == 0) begin
                    if (o_uart_tx != 1'b0) begin
                        rx_bad  <= rx_bad + 1;
                        rx_busy <= 1'b0;
                    end
                end else if (rx_cnt / CPB <= 8) begin
                    rx_sh[rx_cnt / CPB - 1] <= o_uart_tx;
                end else begin
                    if (o_uart_tx != 1'b1) rx_bad <= rx_bad + 1;
                    rxq.push_back(rx_sh);
                    rx_busy <= 1'b0;
                end
            end
        end
    end

    int done_cnt = 0;
    always @(negedge clk) if (o_done === 1'b1) done_cnt <= done_cnt + 1;

    logic [8:0] rdq[$];
    logic       prev_busy = 1'b0;
    logic [8:0] prev_addr = 9'd0;
    always @(negedge clk) begin
        prev_busy <= o_busy;
        prev_addr <= o_rd_addr;
        if (o_busy && (!prev_busy || o_rd_addr != prev_addr)) rdq.push_back(o_rd_addr);
    end

    logic meas_en = 1'b0;
    logic run_val = 1'b1;
    int   run_len = 0;
    int   run_lens[$];
    logic run_vals[$];
    always @(negedge clk) begin
        if (meas_en) begin
            if (o_uart_tx == run_val) begin
                run_len <= run_len + 1;
            end else begin
                run_lens.push_back(run_len);
                run_vals.push_back(run_val);
                run_val <= o_uart_tx;
                run_len <= 1;
            end
        end else begin
            run_val <= o_uart_tx;
            run_len <= 1;
        end
    end

    // ---------------- helpers ----------------
    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, expv);
        end
    endtask

    // '|' in an expected string stands for CR LF.
    function automatic bq_t expand(input string s);
        bq_t r;
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h7C) begin
                r.push_back(8'h0D);
                r.push_back(8'h0A);
            end else begin
                r.push_back(s[i]);
            end
        end
        return r;
    endfunction

    function automatic string hdr(input int m, input int n);
        string s;
        s = $sformatf("%0d*%0d|", m, n);
`ifndef MATRIX_UART_TX_HEADER_EN
        s = "";
`endif
        return s;
    endfunction

    task automatic check_stream(input string tag, input string s);
        bq_t e;
        int  n;
        e = expand(s);
        check_eq({tag, " length"}, rxq.size(), e.size());
        n = (rxq.size() < e.size()) ? rxq.size() : e.size();
        for (int i = 0; i < n; i++)
            check_eq($sformatf("%s byte%0d", tag, i), rxq[i], e[i]);
        rxq.delete();
    endtask

    task automatic pulse_start(input logic [8:0] base, input logic [31:0] m, input logic [31:0] n);
        @(posedge clk); #1;
        i_start = 1'b1; i_base_addr = base; i_m = m; i_n = n;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int k = 0;
        while (o_done !== 1'b1 && k < limit) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, " done seen"}, o_done === 1'b1, 1);
    endtask

    task automatic run_xfer(input string tag, input logic [8:0] base, input logic [31:0] m,
                            input logic [31:0] n, input string s);
        int d0;
        d0 = done_cnt;
        pulse_start(base, m, n);
        wait_done(tag, 20000);
        repeat (4) @(negedge clk);
        check_eq({tag, " done pulses"}, done_cnt - d0, 1);
        check_stream(tag, s);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int d0;
        for (int i = 0; i < 512; i++) mem[i] = 32'd0;
        for (int i = 0; i < 6; i++) mem[9'h010 + i] = 32'(i + 1);
        mem[9'h020] = 32'd0;
        mem[9'h021] = 32'hFFFF_FFFF;
        mem[9'h030] = 32'd7;
        mem[9'h040] = 32'd8;
        mem[9'h041] = 32'd9;
        mem[9'h050] = 32'd77;
        mem[9'h060] = 32'd12345;
        for (int i = 0; i < 9; i++) mem[9'h080 + i] = 32'(i + 1);
        mem[9'h0A0] = 32'd10;
        mem[9'h0A1] = 32'd20;
        mem[9'h0A2] = 32'd30;
        mem[9'h0A3] = 32'd40;

        repeat (3) @(negedge clk);
        check_eq("reset tx", o_uart_tx, 1);
        check_eq("reset busy", o_busy, 0);
        check_eq("reset done", o_done, 0);
        check_eq("reset rd_addr", o_rd_addr, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // 2x3 matrix, address order
        rdq.delete();
        run_xfer("mat2x3", 9'h010, 2, 3, {hdr(2, 3), "1 2 3|4 5 6|"});
        check_eq("mat2x3 reads", rdq.size(), 6);
        for (int i = 0; i < 6 && i < rdq.size(); i++)
            check_eq($sformatf("mat2x3 rd%0d", i), rdq[i], 9'h010 + 9'(i));

        // zero and maximum value
        run_xfer("zero val", 9'h020, 1, 1, {hdr(1, 1), "0|"});
        run_xfer("max val", 9'h021, 1, 1, {hdr(1, 1), "4294967295|"});

        // bit timing of the first frame
        run_lens.delete();
        run_vals.delete();
        meas_en = 1'b1;
        run_xfer("seven", 9'h030, 1, 1, {hdr(1, 1), "7|"});
        meas_en = 1'b0;
`ifndef MATRIX_UART_TX_HEADER_EN
        check_eq("runs recorded", run_lens.size() >= 7, 1);
        if (run_lens.size() >= 7) begin
            check_eq("start level", run_vals[1], 0);
            check_eq("start width", run_lens[1], CPB);
            check_eq("bits0-2 width", run_lens[2], 3 * CPB);
            check_eq("bit3 width", run_lens[3], CPB);
            check_eq("bits4-5 width", run_lens[4], 2 * CPB);
            check_eq("bits6-7 width", run_lens[5], 2 * CPB);
            check_eq("stop+gap in range", run_lens[6] >= CPB && run_lens[6] <= CPB + 4, 1);
        end
`endif
        check_eq("framing errors", rx_bad, 0);

        // zero dimension
`ifndef MATRIX_UART_TX_HEADER_EN
        d0 = done_cnt;
        pulse_start(9'h010, 0, 4);
        check_eq("zero-dim busy t+1", o_busy, 1);
        check_eq("zero-dim done t+1", o_done, 0);
        @(posedge clk); #1;
        check_eq("zero-dim done t+2", o_done, 1);
        check_eq("zero-dim busy t+2", o_busy, 0);
        @(posedge clk); #1;
        check_eq("zero-dim done t+3", o_done, 0);
        repeat (3 * CPB) @(negedge clk);
        check_eq("zero-dim bytes", rxq.size(), 0);
        check_eq("zero-dim line", o_uart_tx, 1);
        check_eq("zero-dim pulses", done_cnt - d0, 1);
        rxq.delete();
`else
        run_xfer("zero-dim hdr", 9'h010, 0, 4, "0*4|");
        run_xfer("hdr 2x2", 9'h0A0, 2, 2, "2*2|10 20|30 40|");
`endif

        // clamping
        run_xfer("clamp m", 9'h080, 9, 1, {hdr(5, 1), "1|2|3|4|5|"});
        run_xfer("clamp n", 9'h080, 1, 100, {hdr(1, 5), "1 2 3 4 5|"});

        // start during transfer and in the done cycle are both ignored
        d0 = done_cnt;
        pulse_start(9'h040, 1, 2);
        repeat (40) @(posedge clk);
        pulse_start(9'h050, 3, 3);
        wait_done("ignore", 20000);
        i_start = 1'b1; i_base_addr = 9'h050; i_m = 32'd1; i_n = 32'd1;
        @(posedge clk); #1 i_start = 1'b0;
        repeat (4 * CPB) @(negedge clk);
        check_eq("ignore busy after done", o_busy, 0);
        check_eq("ignore pulses", done_cnt - d0, 1);
        check_stream("ignore", {hdr(1, 2), "8 9|"});

        // reset mid-byte, then a clean restart
        pulse_start(9'h060, 1, 1);
        repeat (60) @(posedge clk); #1;
        check_eq("pre-reset line low", o_uart_tx, 0);
        rst_n = 1'b0;
        #1;
        check_eq("mid reset tx", o_uart_tx, 1);
        check_eq("mid reset busy", o_busy, 0);
        check_eq("mid reset done", o_done, 0);
        check_eq("mid reset rd_addr", o_rd_addr, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        rxq.delete();
        run_xfer("after reset", 9'h060, 1, 1, {hdr(1, 1), "12345|"});
        check_eq("final framing errors", rx_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matrix_uart_tx.md
Name: matrix_uart_tx

Overview:
- Transmit-side counterpart of the UART matrix input path.
- Reads an m×n matrix row-major from Matrix_storage, starting at a base address.
- Converts each 32-bit unsigned element to decimal ASCII, formats it as text, and serialises it on a UART TX pin, 8N1.
- Sits beside Storage_Mux as a storage reader; the FSM starts it and waits for o_done.

Parameters:
- CLKS_PER_BIT, 217, clk cycles per UART bit (25 MHz / 115200).
- MAX_DIM, 5, largest accepted m or n; larger values are clamped to MAX_DIM.

Ports:
- clk  input  1  system clock (divided 25 MHz clock)
- rst_n  input  1  asynchronous active-low reset
- i_start  input  1  single-cycle start pulse; ignored while o_busy=1
- i_base_addr  input  9  storage address of element (0,0)
- i_m  input  32  row count, sampled on i_start
- i_n  input  32  column count, sampled on i_start
- o_rd_addr  output  9  storage read address
- i_rd_data  input  32  storage read data, valid 1 cycle after o_rd_addr
- o_busy  output  1  high from the cycle after an accepted i_start until o_done
- o_done  output  1  one-cycle pulse after the last stop bit completes
- o_uart_tx  output  1  serial line, idle high

Behaviour:
- Reset values: o_uart_tx=1, o_busy=0, o_done=0, o_rd_addr=0. All counters clear and the FSM returns to IDLE.
- Reset asserted mid-frame: the line returns high immediately and the partial frame is abandoned.
- i_start latches i_base_addr, m and n:
  - m and n are clamped to MAX_DIM.
  - m=0 or n=0: o_done pulses 2 cycles after i_start, no bytes are sent, and o_busy is high for exactly 1 cycle.
- Element address = i_base_addr + r*n + c, computed in 9 bits with wrap-around modulo 512.
- FSM states: IDLE → RD_REQ → RD_WAIT → CONV → SEND_DIGIT → SEP → next element, then DONE.
  - RD_REQ drives o_rd_addr.
  - RD_WAIT takes 1 cycle; i_rd_data is registered into a working value at its end.
  - CONV processes powers 10^9 down to 10^0 by repeated subtraction, one subtraction or one power step per cycle. When a power finishes, it yields a digit.
  - Leading zeros are suppressed. Value 0 emits the single byte "0" (0x30).
  - Each non-suppressed digit goes to SEND_DIGIT: the byte is handed to the serialiser, and the FSM waits for the serialiser to go idle before continuing CONV.
- Separators:
  - Between elements in a row: one space (0x20).
  - After the last element of each row: 0x0D then 0x0A.
  - There is no trailing space.
- Serialiser:
  - Start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts exactly CLKS_PER_BIT cycles.
  - Back-to-back bytes may have zero idle cycles between the stop bit and the next start bit. Any gap must not exceed 4 cycles.
- DONE: o_done=1 for one cycle in the cycle after the final 0x0A stop bit ends; o_busy falls in that same cycle; the FSM returns to IDLE.
- i_rd_data is sampled only at the end of RD_WAIT. o_rd_addr holds its value from RD_REQ through RD_WAIT.
- An i_start pulse arriving in the same cycle as o_done is ignored.

Optional Feature:
- Macro: MATRIX_UART_TX_HEADER_EN.
- Defined: before the first element, emit the header m (decimal), "*" (0x2A), n (decimal), 0x0D, 0x0A, using the clamped values. If m=0 or n=0, only the header "0*n\r\n" or "m*0\r\n" is sent, then o_done.
- Undefined: no header. Behaviour is exactly as above.

Test Plan:
- 2×3 matrix at base 0x010 holding 1,2,3,4,5,6 → byte stream "1 2 3\r\n4 5 6\r\n" (14 bytes). Reads hit 0x010–0x015 in order. o_done pulses once.
- 1×1 element 0 then 1×1 element 0xFFFFFFFF → "0\r\n" then "4294967295\r\n". No leading zeros in either.
- Bit timing: single element 7 → first frame is start bit, 0x37 LSB first, stop bit. Each bit is held 217±0 cycles, measured at the pin.
- i_m=0, i_n=4 → no line activity, o_done 2 cycles after i_start. Second case: i_m=9 clamps to 5 rows.
- Second i_start mid-transfer with a different base → ignored, and the output stream is unchanged. Next, assert rst_n=0 mid-byte → o_uart_tx=1 and o_busy=0 immediately; a new i_start after release produces a correct full stream.
- With MATRIX_UART_TX_HEADER_EN, 2×2 of 10,20,30,40 → "2*2\r\n10 20\r\n30 40\r\n".
